hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-strand register hazard tracker: shift register of in-flight writers plus
// one outstanding long-latency destination per strand; chk_hazard is combinational.
module hazard_scoreboard #(
  parameter int STRANDS       = 4,
  parameter int PIPE_DEPTH    = 5,
  parameter int REG_IDX_WIDTH = 5,
  parameter int BYPASS_LAST   = 1,
  localparam int SW = $clog2(STRANDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [SW-1:0]            issue_strand,
  input  logic                     issue_writes,
  input  logic [REG_IDX_WIDTH-1:0] issue_dest,
  input  logic                     issue_dest_vector,
  input  logic                     issue_long_latency,
  input  logic [SW-1:0]            chk_strand,
  input  logic [REG_IDX_WIDTH-1:0] chk_src1,
  input  logic [REG_IDX_WIDTH-1:0] chk_src2,
  input  logic                     chk_src1_vector,
  input  logic                     chk_src2_vector,
  output logic                     chk_hazard,
  input  logic                     rollback_valid,
  input  logic [SW-1:0]            rollback_strand,
  input  logic [2:0]               rollback_stage,
  input  logic                     ll_complete_valid,
  input  logic [SW-1:0]            ll_complete_strand,
  output logic [STRANDS-1:0]       strand_ll_pending,
  output logic                     pipe_empty
);

  localparam int LAST     = PIPE_DEPTH - 1;
  localparam int CHK_LAST = (BYPASS_LAST != 0) ? PIPE_DEPTH - 2 : PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0]    valid_q, valid_d, vec_q, vec_d, ll_q, ll_d, live;
  logic [SW-1:0]            strand_q [PIPE_DEPTH];
  logic [SW-1:0]            strand_d [PIPE_DEPTH];
  logic [REG_IDX_WIDTH-1:0] dest_q   [PIPE_DEPTH];
  logic [REG_IDX_WIDTH-1:0] dest_d   [PIPE_DEPTH];
  logic [STRANDS-1:0]       pend_q, pend_d, pend_vec_q, pend_vec_d;
  logic [REG_IDX_WIDTH-1:0] pend_dest_q [STRANDS];
  logic [REG_IDX_WIDTH-1:0] pend_dest_d [STRANDS];
  logic                     ll_exit;
  logic [SW-1:0]            exit_strand;

  // Rollback masks the current entries first, so squashed writers never advance.
  always_comb begin
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      live[i] = valid_q[i] && !(rollback_valid && (strand_q[i] == rollback_strand) &&
                                (i <= int'(rollback_stage)));
    end
    valid_d[0]  = issue_valid && issue_writes &&
                  !(rollback_valid && (issue_strand == rollback_strand));
    strand_d[0] = issue_strand;
    dest_d[0]   = issue_dest;
    vec_d[0]    = issue_dest_vector;
    ll_d[0]     = issue_long_latency;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      valid_d[i]  = live[i-1];
      strand_d[i] = strand_q[i-1];
      dest_d[i]   = dest_q[i-1];
      vec_d[i]    = vec_q[i-1];
      ll_d[i]     = ll_q[i-1];
    end
  end

  assign ll_exit     = live[LAST] && ll_q[LAST];
  assign exit_strand = strand_q[LAST];

  // Clear first so a simultaneous exit on the same strand wins.
  always_comb begin
    pend_d      = pend_q;
    pend_vec_d  = pend_vec_q;
    pend_dest_d = pend_dest_q;
    if (ll_complete_valid) pend_d[ll_complete_strand] = 1'b0;
    if (ll_exit) begin
      pend_d[exit_strand]      = 1'b1;
      pend_vec_d[exit_strand]  = vec_q[LAST];
      pend_dest_d[exit_strand] = dest_q[LAST];
    end
  end

  always_comb begin
    chk_hazard = 1'b0;
    for (int i = 0; i <= CHK_LAST; i++) begin
      if (valid_q[i] && (strand_q[i] == chk_strand) &&
          (((dest_q[i] == chk_src1) && (vec_q[i] == chk_src1_vector)) ||
           ((dest_q[i] == chk_src2) && (vec_q[i] == chk_src2_vector))))
        chk_hazard = 1'b1;
    end
    if (pend_q[chk_strand] &&
        (((pend_dest_q[chk_strand] == chk_src1) && (pend_vec_q[chk_strand] == chk_src1_vector)) ||
         ((pend_dest_q[chk_strand] == chk_src2) && (pend_vec_q[chk_strand] == chk_src2_vector))))
      chk_hazard = 1'b1;
  end

  assign strand_ll_pending = pend_q;
  assign pipe_empty        = (valid_q == '0) && (pend_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      vec_q      <= '0;
      ll_q       <= '0;
      pend_q     <= '0;
      pend_vec_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        strand_q[i] <= '0;
        dest_q[i]   <= '0;
      end
      for (int s = 0; s < STRANDS; s++) pend_dest_q[s] <= '0;
    end else begin
      valid_q    <= valid_d;
      vec_q      <= vec_d;
      ll_q       <= ll_d;
      pend_q     <= pend_d;
      pend_vec_q <= pend_vec_d;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        strand_q[i] <= strand_d[i];
        dest_q[i]   <= dest_d[i];
      end
      for (int s = 0; s < STRANDS; s++) pend_dest_q[s] <= pend_dest_d[s];
    end
  end

  // A second exit while pending overwrites the earlier destination.
  ll_overwrite_a: assert property (@(posedge clk) disable iff (reset)
    !(ll_exit && pend_q[exit_strand] &&
      !(ll_complete_valid && (ll_complete_strand == exit_strand))));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against an age-list reference model,
// preceded by directed scenarios for the key corner cases.
module tb_hazard_scoreboard;
  localparam int ST = 4;
  localparam int PD = 5;
  localparam int RW = 5;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_writes, issue_dest_vector, issue_long_latency;
  logic [SW-1:0] issue_strand, chk_strand, rollback_strand, ll_complete_strand;
  logic [RW-1:0] issue_dest, chk_src1, chk_src2;
  logic          chk_src1_vector, chk_src2_vector, chk_hazard;
  logic          rollback_valid, ll_complete_valid, pipe_empty;
  logic [2:0]    rollback_stage;
  logic [ST-1:0] strand_ll_pending;

  hazard_scoreboard #(.STRANDS(ST), .PIPE_DEPTH(PD), .REG_IDX_WIDTH(RW), .BYPASS_LAST(1)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_strand(issue_strand), .issue_writes(issue_writes),
    .issue_dest(issue_dest), .issue_dest_vector(issue_dest_vector),
    .issue_long_latency(issue_long_latency),
    .chk_strand(chk_strand), .chk_src1(chk_src1), .chk_src2(chk_src2),
    .chk_src1_vector(chk_src1_vector), .chk_src2_vector(chk_src2_vector),
    .chk_hazard(chk_hazard),
    .rollback_valid(rollback_valid), .rollback_strand(rollback_strand),
    .rollback_stage(rollback_stage),
    .ll_complete_valid(ll_complete_valid), .ll_complete_strand(ll_complete_strand),
    .strand_ll_pending(strand_ll_pending), .pipe_empty(pipe_empty)
  );

  always #5 clk = ~clk;

  typedef struct {int strand; int dest; int vec; int ll; int age;} rec_t;
  rec_t mq[$];
  int   pend[ST], pdest[ST], pvec[ST];
  int   n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int src_match(input int d, input int v);
    return ((d == int'(chk_src1)) && (v == int'(chk_src1_vector))) ||
           ((d == int'(chk_src2)) && (v == int'(chk_src2_vector)));
  endfunction

  // Writers are visible for ages 0..PD-2; the final stage is forwarded by bypass.
  function automatic int model_hazard();
    int h = 0;
    foreach (mq[k])
      if (mq[k].age <= PD - 2 && mq[k].strand == int'(chk_strand) &&
          src_match(mq[k].dest, mq[k].vec) != 0) h = 1;
    if (pend[chk_strand] != 0 && src_match(pdest[chk_strand], pvec[chk_strand]) != 0) h = 1;
    return h;
  endfunction

  function automatic int model_pend_vec();
    int v = 0;
    for (int s = 0; s < ST; s++) if (pend[s] != 0) v += (1 << s);
    return v;
  endfunction

  function automatic int ll_ok(input int s);
    if (pend[s] != 0) return 0;
    foreach (mq[k]) if (mq[k].strand == s && mq[k].ll != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int s = 0; s < ST; s++) begin pend[s] = 0; pdest[s] = 0; pvec[s] = 0; end
  endtask

  task automatic model_update();
    rec_t nq[$];
    if (ll_complete_valid) pend[ll_complete_strand] = 0;
    foreach (mq[k]) begin
      rec_t r = mq[k];
      if (rollback_valid && r.strand == int'(rollback_strand) && r.age <= int'(rollback_stage))
        continue;
      r.age++;
      if (r.age >= PD) begin
        if (r.ll != 0) begin pend[r.strand] = 1; pdest[r.strand] = r.dest; pvec[r.strand] = r.vec; end
      end else nq.push_back(r);
    end
    if (issue_valid && issue_writes && !(rollback_valid && issue_strand == rollback_strand))
      nq.push_back('{int'(issue_strand), int'(issue_dest), int'(issue_dest_vector),
                     int'(issue_long_latency), 0});
    mq = nq;
  endtask

  task automatic model_check();
    chk("hazard", int'(chk_hazard), model_hazard());
    chk("ll_pending", int'(strand_ll_pending), model_pend_vec());
    chk("pipe_empty", int'(pipe_empty), (mq.size() == 0 && model_pend_vec() == 0) ? 1 : 0);
  endtask

  // Inputs are driven just after negedge; outputs checked 1ns later.
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_strand = 0; issue_writes = 0; issue_dest = 0;
    issue_dest_vector = 0; issue_long_latency = 0;
    rollback_valid = 0; rollback_strand = 0; rollback_stage = 0;
    ll_complete_valid = 0; ll_complete_strand = 0;
  endtask

  task automatic issue(input int s, input int d, input int v, input int ll);
    idle();
    issue_valid = 1; issue_writes = 1; issue_strand = s[SW-1:0];
    issue_dest = d[RW-1:0]; issue_dest_vector = v[0]; issue_long_latency = ll[0];
  endtask

  task automatic set_chk(input int s, input int a, input int av, input int b, input int bv);
    chk_strand = s[SW-1:0]; chk_src1 = a[RW-1:0]; chk_src1_vector = av[0];
    chk_src2 = b[RW-1:0]; chk_src2_vector = bv[0];
  endtask

  initial begin
    reset = 1; idle(); set_chk(0, 31, 0, 31, 0); model_reset();
    #1;
    chk("rst_hazard", int'(chk_hazard), 0);
    chk("rst_empty", int'(pipe_empty), 1);
    chk("rst_pending", int'(strand_ll_pending), 0);
    @(negedge clk); @(negedge clk); reset = 0;

    // Scalar writer visible PD-1 cycles; other strand never hazards.
    issue(1, 5, 0, 0); step(); idle(); set_chk(1, 5, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin #1 chk("s5_hazard", int'(chk_hazard), (k < PD - 1) ? 1 : 0); step(); end
    issue(1, 5, 0, 0); step(); idle(); set_chk(2, 5, 0, 5, 0);
    for (int k = 0; k < 6; k++) begin #1 chk("s5_other_strand", int'(chk_hazard), 0); step(); end

    // Long-latency vector writer becomes pending, clears on completion.
    issue(0, 3, 1, 1); step(); idle(); set_chk(0, 3, 1, 0, 1);
    for (int k = 0; k < PD; k++) begin #1 chk("v3_inflight", int'(chk_hazard), (k < PD - 1) ? 1 : 0); step(); end
    #1 chk("v3_pending", int'(strand_ll_pending[0]), 1);
    chk("v3_pend_hazard", int'(chk_hazard), 1);
    set_chk(0, 3, 0, 3, 0); #1 chk("s3_no_hazard", int'(chk_hazard), 0);
    set_chk(0, 3, 1, 0, 1); step();
    ll_complete_valid = 1; ll_complete_strand = 0; step(); idle();
    #1 chk("v3_cleared", int'(strand_ll_pending[0]), 0);
    chk("v3_clr_hazard", int'(chk_hazard), 0);

    // Rollback of strand 2 stages 0..2.
    for (int d = 1; d <= 5; d++) begin issue(2, d, 0, 0); step(); end
    idle(); set_chk(2, 2, 0, 3, 0);
    #1 chk("rb_pre_hazard", int'(chk_hazard), 1);
    rollback_valid = 1; rollback_strand = 2; rollback_stage = 2; step(); idle();
    set_chk(2, 3, 0, 4, 0); #1 chk("rb_s3s4_gone", int'(chk_hazard), 0);
    set_chk(2, 5, 0, 5, 0); #1 chk("rb_s5_gone", int'(chk_hazard), 0);
    chk("rb_s2_kept", int'(pipe_empty), 0);
    for (int k = 0; k < PD; k++) step();

    // Issue and rollback same strand same cycle.
    issue(3, 8, 0, 0); rollback_valid = 1; rollback_strand = 3; rollback_stage = 0;
    set_chk(3, 8, 0, 8, 0); step(); idle();
    for (int k = 0; k < PD; k++) begin #1 chk("squash_empty", int'(pipe_empty), 1); step(); end

    // Second long-latency exit coinciding with completion of the first.
    issue(1, 7, 0, 1); step(); idle();
    for (int k = 0; k < PD; k++) step();
    issue(1, 9, 0, 1); step(); idle();
    for (int k = 0; k < PD - 1; k++) step();
    ll_complete_valid = 1; ll_complete_strand = 1; step(); idle();
    set_chk(1, 9, 0, 9, 0);
    #1 chk("ovr_pending", int'(strand_ll_pending[1]), 1);
    chk("ovr_new_dest", int'(chk_hazard), 1);
    set_chk(1, 7, 0, 7, 0); #1 chk("ovr_old_dest", int'(chk_hazard), 0);

    // Reset mid-operation with 2 pending strands and 4 live entries.
    issue(0, 2, 0, 1); step(); idle();
    for (int k = 0; k < PD; k++) step();
    for (int d = 10; d < 14; d++) begin issue(3, d, 0, 0); step(); end
    idle(); set_chk(3, 11, 0, 12, 0);
    #1 chk("pre_rst_hazard", int'(chk_hazard), 1);
    chk("pre_rst_pending", int'(strand_ll_pending), 3);
    reset = 1; model_reset();
    #1 chk("mid_rst_hazard", int'(chk_hazard), 0);
    chk("mid_rst_empty", int'(pipe_empty), 1);
    chk("mid_rst_pending", int'(strand_ll_pending), 0);
    @(negedge clk); reset = 0;
    issue(3, 10, 0, 0); set_chk(3, 10, 0, 10, 0); step(); idle();
    #1 chk("post_rst_hazard", int'(chk_hazard), 1);
    step();

    for (int n = 0; n < 3000; n++) begin
      int s = $urandom_range(ST - 1);
      idle();
      issue_valid = ($urandom_range(3) != 0);
      issue_strand = s[SW-1:0];
      issue_writes = ($urandom_range(3) != 0);
      issue_dest = 5'($urandom_range(7));
      issue_dest_vector = $urandom_range(1);
      issue_long_latency = ($urandom_range(3) == 0) && (ll_ok(s) != 0);
      rollback_valid = ($urandom_range(9) == 0);
      rollback_strand = 2'($urandom_range(ST - 1));
      rollback_stage = 3'($urandom_range(7));
      ll_complete_valid = ($urandom_range(7) == 0);
      ll_complete_strand = 2'($urandom_range(ST - 1));
      set_chk($urandom_range(ST - 1), $urandom_range(7), $urandom_range(1),
              $urandom_range(7), $urandom_range(1));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
